// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// shift-add multiply and restoring divide. Optional status flags: SEQ_ALU_FLAGS_EN.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C,
  output logic               div_by_zero,
  output logic               illegal_op
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic               zero,
  output logic               negative,
  output logic               carry,
  output logic               overflow
`endif
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_XOR  = 5'b01101,
    OP_NOR  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_NOP  = 5'b11010
  } op_e;

  typedef enum logic [2:0] {IDLE, EXEC1, MUL_ITER, DIV_ITER, FIXUP} state_e;

  state_e               state_q, state_d;
  logic [4:0]           opc_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [WIDTH-1:0]     hi_q, lo_q, dsr_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic                 prep_q;

  logic [SHAMT_W-1:0]   amt;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_ill;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum, div_sh, div_try;
  logic [2*WIDTH-1:0]   mag, prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic                 sgn;
  logic [2*WIDTH-1:0]   fin_c;
  logic                 fin_dbz, fin_ill;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (opcode == OP_MUL)      state_d = MUL_ITER;
          else if (opcode == OP_DIV) state_d = DIV_ITER;
          else                       state_d = EXEC1;
        end
      end
      EXEC1: state_d = IDLE;
      MUL_ITER, DIV_ITER: begin
        if (!prep_q && cnt_q == SHAMT_W'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results from the latched operands
  always_comb begin
    amt    = b_q[SHAMT_W-1:0];
    sc_res = '0;
    sc_ill = 1'b0;
    case (opc_q)
      OP_ADD:  sc_res = a_q + b_q;
      OP_SUB:  sc_res = a_q - b_q;
      OP_AND:  sc_res = a_q & b_q;
      OP_OR:   sc_res = a_q | b_q;
      OP_XOR:  sc_res = a_q ^ b_q;
      OP_NOR:  sc_res = ~(a_q | b_q);
      OP_NOT:  sc_res = ~a_q;
      OP_NEG:  sc_res = -a_q;
      OP_SHR:  sc_res = a_q >> amt;
      OP_SHL:  sc_res = a_q << amt;
      OP_SHRA: sc_res = $signed(a_q) >>> amt;
      // a shift by WIDTH yields zero, so amount 0 returns A unchanged
      OP_ROR:  sc_res = (a_q >> amt) | (a_q << (WIDTH - amt));
      OP_ROL:  sc_res = (a_q << amt) | (a_q >> (WIDTH - amt));
      OP_NOP, OP_MUL, OP_DIV: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    a_abs   = a_q[WIDTH-1] ? -a_q : a_q;
    b_abs   = b_q[WIDTH-1] ? -b_q : b_q;
    sgn     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_try = div_sh - {1'b0, dsr_q};
    mag     = {hi_q, lo_q};
    prod_s  = sgn ? -mag : mag;
    quo_s   = sgn ? -lo_q : lo_q;
    rem_s   = a_q[WIDTH-1] ? -hi_q : hi_q;
  end

  always_comb begin
    fin_c   = {{WIDTH{1'b0}}, sc_res};
    fin_dbz = 1'b0;
    fin_ill = sc_ill;
    if (state_q == FIXUP) begin
      fin_ill = 1'b0;
      if (opc_q == OP_MUL) begin
        fin_c = prod_s;
      end else if (b_q == '0) begin
        fin_c   = {a_q, {WIDTH{1'b1}}};
        fin_dbz = 1'b1;
      end else begin
        fin_c = {rem_s, quo_s};
      end
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic fl_carry, fl_ovf, fl_neg;

  always_comb begin
    fl_carry = 1'b0;
    fl_ovf   = 1'b0;
    fl_neg   = (state_q == FIXUP && opc_q == OP_MUL) ? fin_c[2*WIDTH-1] : fin_c[WIDTH-1];
    if (state_q == EXEC1) begin
      case (opc_q)
        OP_ADD: begin
          fl_carry = (sc_res < a_q);
          fl_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sc_res[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          fl_carry = (a_q >= b_q);
          fl_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sc_res[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_NEG:  fl_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
        default: ;
      endcase
    end
  end
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      opc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      prep_q      <= 1'b0;
      done        <= 1'b0;
      C           <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      zero        <= 1'b0;
      negative    <= 1'b0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opc_q  <= opcode;
            a_q    <= A;
            b_q    <= B;
            prep_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        EXEC1, FIXUP: begin
          C           <= fin_c;
          done        <= 1'b1;
          div_by_zero <= fin_dbz;
          illegal_op  <= fin_ill;
`ifdef SEQ_ALU_FLAGS_EN
          zero        <= (fin_c == '0);
          negative    <= fl_neg;
          carry       <= fl_carry;
          overflow    <= fl_ovf;
`endif
        end
        // First iterative cycle loads magnitudes; the next WIDTH cycles iterate
        MUL_ITER: begin
          if (prep_q) begin
            hi_q   <= '0;
            lo_q   <= b_abs;
            dsr_q  <= a_abs;
            prep_q <= 1'b0;
          end else begin
            hi_q  <= mul_sum[WIDTH:1];
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + SHAMT_W'(1);
          end
        end
        DIV_ITER: begin
          if (prep_q) begin
            hi_q   <= '0;
            lo_q   <= a_abs;
            dsr_q  <= b_abs;
            prep_q <= 1'b0;
          end else begin
            if (!div_try[WIDTH]) begin
              hi_q <= div_try[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_q <= div_sh[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + SHAMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a plain-arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110,
                         ROR = 5'b00111, ROL = 5'b01000, SHR = 5'b01001, SHRA = 5'b01010,
                         SHL = 5'b01011, XOR_ = 5'b01101, NOR_ = 5'b01110, DIV = 5'b01111,
                         MUL = 5'b10000, NEG = 5'b10001, NOT_ = 5'b10010, NOP = 5'b11010;

  logic         clock = 1'b0, clear = 1'b0, start = 1'b0;
  logic [4:0]   opcode = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, div_by_zero, illegal_op;
  logic [2*W-1:0] C;
`ifdef SEQ_ALU_FLAGS_EN
  logic zero, negative, carry, overflow;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .busy(busy), .done(done), .C(C), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
`ifdef SEQ_ALU_FLAGS_EN
    , .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          dc;
    logic [63:0] c;
    logic        dbz, ill, z, n, cy, ov;
  } exp_t;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    return (op == MUL || op == DIV) ? W + 2 : 1;
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, ua, ub, p, q, r;
    logic [31:0] lo;
    int n;
    e  = '{default: 0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    n  = int'(b[4:0]);
    lo = '0;
    case (op)
      ADD:  lo = a + b;
      SUB:  lo = a - b;
      AND_: lo = a & b;
      OR_:  lo = a | b;
      XOR_: lo = a ^ b;
      NOR_: lo = ~(a | b);
      NOT_: lo = ~a;
      NEG:  lo = 32'd0 - a;
      SHR:  lo = a >> n;
      SHL:  lo = a << n;
      SHRA: begin p = sa >>> n; lo = p[31:0]; end
      ROR:  for (int i = 0; i < 32; i++) lo[i] = a[(i + n) % 32];
      ROL:  for (int i = 0; i < 32; i++) lo[(i + n) % 32] = a[i];
      MUL, DIV, NOP: ;
      default: e.ill = 1'b1;
    endcase
    e.c = {32'b0, lo};
    if (op == MUL) begin
      p = sa * sb;
      e.c = p;
    end else if (op == DIV) begin
      if (b == 0) begin
        e.c = {a, 32'hFFFF_FFFF};
        e.dbz = 1'b1;
      end else begin
        q = sa / sb;
        r = sa % sb;
        e.c = {r[31:0], q[31:0]};
      end
    end
    e.z = (e.c == 0);
    e.n = (op == MUL) ? e.c[63] : e.c[31];
    if (op == ADD) begin
      e.cy = (ua + ub) > 64'sh0000_0000_FFFF_FFFF;
      e.ov = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
    end else if (op == SUB) begin
      e.cy = (ua >= ub);
      e.ov = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
    end else if (op == NEG) begin
      e.ov = (-sa > 64'sd2147483647);
    end
    return e;
  endfunction

  // Model side: which request is accepted and when its result must appear
  int   cyc = 0, free_cyc = 0;
  exp_t cur;
  bit   cur_valid = 0;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_valid = 0;
      free_cyc  = 0;
    end else begin
      cyc++;
      if (start && cyc > free_cyc) begin
        cur       = model(opcode, A, B);
        cur.dc    = cyc + lat_of(opcode);
        cur_valid = 1;
        free_cyc  = cur.dc;
      end
    end
  end

  logic [63:0] h_c = '0;
  logic h_dbz = 0, h_ill = 0, h_z = 0, h_n = 0, h_cy = 0, h_ov = 0;
  int done_count = 0;

  always @(negedge clock or negedge clear) begin
    bit exp_done, exp_busy;
    if (!clear) begin
      h_c = '0; h_dbz = 0; h_ill = 0; h_z = 0; h_n = 0; h_cy = 0; h_ov = 0;
    end else begin
      exp_done = cur_valid && (cur.dc == cyc);
      exp_busy = cur_valid && (cyc < cur.dc);
      chk("busy", {63'b0, busy}, {63'b0, exp_busy});
      chk("done", {63'b0, done}, {63'b0, exp_done});
      if (done === 1'b1) done_count++;
      if (exp_done) begin
        h_c = cur.c; h_dbz = cur.dbz; h_ill = cur.ill;
        h_z = cur.z; h_n = cur.n; h_cy = cur.cy; h_ov = cur.ov;
      end
      chk("C", C, h_c);
      chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, h_dbz});
      chk("illegal_op", {63'b0, illegal_op}, {63'b0, h_ill});
`ifdef SEQ_ALU_FLAGS_EN
      chk("zero", {63'b0, zero}, {63'b0, h_z});
      chk("negative", {63'b0, negative}, {63'b0, h_n});
      chk("carry", {63'b0, carry}, {63'b0, h_cy});
      chk("overflow", {63'b0, overflow}, {63'b0, h_ov});
`endif
    end
  end

  // Call at a negedge where the DUT will accept; returns at the negedge of done
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int lat_o);
    int k;
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clock); #1;
    k = cyc;
    @(negedge clock);
    start = 1'b0;
    lat_o = -1;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        lat_o = cyc - k;
        break;
      end
      @(negedge clock);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, d0;
    logic [4:0] ops [16];
    logic [4:0] op;
    ops = '{ADD, SUB, AND_, OR_, ROR, ROL, SHR, SHRA, SHL, XOR_, NOR_, DIV, MUL, NEG, NOT_, NOP};

    repeat (3) @(negedge clock);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset done", {63'b0, done}, 64'd0);
    chk("reset C", C, 64'd0);
    chk("reset dbz", {63'b0, div_by_zero}, 64'd0);
    chk("reset ill", {63'b0, illegal_op}, 64'd0);
    #2 clear = 1'b1;
    @(negedge clock);

    run(ADD, 32'd7, 32'd5, lat);
    chk("add lat", lat, 64'd1);
    chk("add C", C, 64'h0000_0000_0000_000C);

    run(MUL, 32'hFFFF_FFFD, 32'd5, lat);
    chk("mul lat", lat, 64'd34);
    chk("mul -3*5", C, 64'hFFFF_FFFF_FFFF_FFF1);
    run(MUL, 32'h8000_0000, 32'h8000_0000, lat);
    chk("mul min*min", C, 64'h4000_0000_0000_0000);

    run(DIV, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div -7/2", C, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div -7/2 dbz", {63'b0, div_by_zero}, 64'd0);
    run(DIV, 32'd9, 32'd0, lat);
    chk("div0 lat", lat, 64'd34);
    chk("div 9/0", C, 64'h0000_0009_FFFF_FFFF);
    chk("div0 dbz", {63'b0, div_by_zero}, 64'd1);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div min/-1", C, 64'h0000_0000_8000_0000);
    chk("div min/-1 dbz", {63'b0, div_by_zero}, 64'd0);

    run(ROR, 32'd1, 32'd1, lat);
    chk("ror 1,1", C, 64'h0000_0000_8000_0000);
    run(SHRA, 32'h8000_0000, 32'd4, lat);
    chk("shra", C, 64'h0000_0000_F800_0000);
    run(SHL, 32'd1, 32'd33, lat);
    chk("shl masked", C, 64'h0000_0000_0000_0002);

    // start held high with changing opcode while busy: only one op runs
    start = 1'b1; opcode = MUL; A = 32'd6; B = 32'd7;
    @(posedge clock); #1;
    k = cyc; d0 = done_count; lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin lat = cyc - k; break; end
      opcode = ADD; A = $urandom;
    end
    start = 1'b0;
    chk("hold lat", lat, 64'd34);
    chk("hold C", C, 64'd42);
    repeat (3) @(negedge clock);
    #1 chk("hold done count", done_count - d0, 64'd1);
    @(negedge clock);

    run(5'b11111, 32'd3, 32'd4, lat);
    chk("illegal flag", {63'b0, illegal_op}, 64'd1);
    chk("illegal C", C, 64'd0);
    run(MUL, 32'd6, 32'd7, lat);

    // asynchronous clear in the middle of a multiply
    start = 1'b1; opcode = MUL; A = 32'hFFFF_FFFD; B = 32'd5;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    chk("clr busy", {63'b0, busy}, 64'd0);
    chk("clr done", {63'b0, done}, 64'd0);
    chk("clr C", C, 64'd0);
    chk("clr ill", {63'b0, illegal_op}, 64'd0);
    @(negedge clock);
    #2 clear = 1'b1;
    @(negedge clock);
    run(ADD, 32'd1, 32'd1, lat);
    chk("post-clr lat", lat, 64'd1);
    chk("post-clr C", C, 64'd2);

`ifdef SEQ_ALU_FLAGS_EN
    run(ADD, 32'h7FFF_FFFF, 32'd1, lat);
    chk("flag overflow", {63'b0, overflow}, 64'd1);
    chk("flag negative", {63'b0, negative}, 64'd1);
    chk("flag carry", {63'b0, carry}, 64'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      int idx;
      idx = $urandom_range(0, 19);
      if (idx < 16) op = ops[idx];
      else          op = 5'($urandom_range(0, 31));
      run(op, pick_operand(), pick_operand(), lat);
      chk("rand lat", lat, lat_of(op));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
